// File: rtl/rsa_job_arbiter.sv
// rsa_job_arbiter: round-robin job arbiter in front of a single RSA engine,
// with idle-timeout power-down and wake-on-request power sequencing.
`ifndef CONFIG_DATA_WIDTH
`define CONFIG_DATA_WIDTH 32
`endif

module rsa_job_arbiter #(
  parameter int DATA_WIDTH   = `CONFIG_DATA_WIDTH,
  parameter int N_REQ        = 2,
  parameter int IDLE_TIMEOUT = 64
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 ce,
  input  logic [N_REQ-1:0]                     req_valid,
  input  logic [N_REQ*DATA_WIDTH-1:0]          req_c,
  input  logic [N_REQ*DATA_WIDTH-1:0]          req_d,
  input  logic [N_REQ*DATA_WIDTH-1:0]          req_r2_mod_n,
  input  logic [N_REQ*DATA_WIDTH-1:0]          req_n,
  input  logic [N_REQ*$clog2(DATA_WIDTH)-1:0]  req_t_sub_1,
  output logic [N_REQ-1:0]                     req_accept,
  output logic [N_REQ-1:0]                     resp_valid,
  output logic [DATA_WIDTH-1:0]                resp_m,
  output logic                                 core_start,
  output logic [DATA_WIDTH-1:0]                core_c,
  output logic [DATA_WIDTH-1:0]                core_d,
  output logic [DATA_WIDTH-1:0]                core_r2_mod_n,
  output logic [DATA_WIDTH-1:0]                core_n,
  output logic [$clog2(DATA_WIDTH)-1:0]        core_t_sub_1,
  input  logic                                 core_ready,
  input  logic                                 core_done,
  input  logic [DATA_WIDTH-1:0]                core_m,
  output logic                                 pwr_req_enable,
  output logic                                 pwr_req_disable
);

  localparam int GW = $clog2(N_REQ);
  localparam int TW = $clog2(DATA_WIDTH);
  localparam int CW = $clog2(IDLE_TIMEOUT + 1);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_BUSY, S_SLEEP, S_OFF, S_WAKE} state_t;

  state_t                  state_q, state_d;
  logic [GW-1:0]           last_grant_q, last_grant_d;   // also the requester of the job in flight
  logic [CW-1:0]           idle_cnt_q, idle_cnt_d;
  logic [DATA_WIDTH-1:0]   core_c_q, core_c_d, core_d_q, core_d_d;
  logic [DATA_WIDTH-1:0]   core_r2_q, core_r2_d, core_n_q, core_n_d;
  logic [TW-1:0]           core_t_q, core_t_d;
  logic [DATA_WIDTH-1:0]   resp_m_q, resp_m_d;
  logic [N_REQ-1:0]        resp_valid_q, resp_valid_d;

  logic [GW-1:0]           grant_idx;
  logic                    grant_hit;
  logic [GW:0]             rr_idx;
  logic [N_REQ-1:0]        accept;
  logic                    start, pwr_en, pwr_dis, go;

  // Round-robin pick: scan from last_grant+1 upward (mod N_REQ); lowest offset wins
  always_comb begin
    grant_idx = '0;
    grant_hit = 1'b0;
    rr_idx    = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      rr_idx = {1'b0, last_grant_q} + (GW+1)'(k + 1);
      if (rr_idx >= (GW+1)'(N_REQ)) rr_idx = rr_idx - (GW+1)'(N_REQ);
      if (req_valid[rr_idx[GW-1:0]]) begin
        grant_idx = rr_idx[GW-1:0];
        grant_hit = 1'b1;
      end
    end
  end

  // Next-state, operand latching, idle counting and pulse generation
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    idle_cnt_d   = '0;
    core_c_d     = core_c_q;
    core_d_d     = core_d_q;
    core_r2_d    = core_r2_q;
    core_n_d     = core_n_q;
    core_t_d     = core_t_q;
    resp_m_d     = resp_m_q;
    resp_valid_d = '0;
    accept       = '0;
    start        = 1'b0;
    pwr_en       = 1'b0;
    pwr_dis      = 1'b0;
    case (state_q)
      S_IDLE: begin
        // a pending grant always beats the power-down timeout
        if (grant_hit && core_ready) begin
          state_d           = S_ISSUE;
          last_grant_d      = grant_idx;
          accept[grant_idx] = 1'b1;
          core_c_d  = req_c[grant_idx*DATA_WIDTH +: DATA_WIDTH];
          core_d_d  = req_d[grant_idx*DATA_WIDTH +: DATA_WIDTH];
          core_r2_d = req_r2_mod_n[grant_idx*DATA_WIDTH +: DATA_WIDTH];
          core_n_d  = req_n[grant_idx*DATA_WIDTH +: DATA_WIDTH];
          core_t_d  = req_t_sub_1[grant_idx*TW +: TW];
        end else if (!(|req_valid) && idle_cnt_q >= CW'(IDLE_TIMEOUT - 1)) begin
          pwr_dis = 1'b1;
          state_d = S_SLEEP;
        end else if (idle_cnt_q < CW'(IDLE_TIMEOUT - 1)) begin
          idle_cnt_d = idle_cnt_q + 1'b1;
        end else begin
          idle_cnt_d = idle_cnt_q;
        end
      end
      S_ISSUE: begin
        start   = 1'b1;
        state_d = S_BUSY;
      end
      S_BUSY: begin
        if (core_done) begin
          resp_m_d                   = core_m;
          resp_valid_d[last_grant_q] = 1'b1;
          state_d                    = S_IDLE;
        end
      end
      S_SLEEP: if (!core_ready) state_d = S_OFF;
      S_OFF: begin
        if (|req_valid) begin
          pwr_en  = 1'b1;
          state_d = S_WAKE;
        end
      end
      S_WAKE:  if (core_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State register; everything holds while ce is low
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      last_grant_q <= GW'(N_REQ - 1);
      idle_cnt_q   <= '0;
      core_c_q     <= '0;
      core_d_q     <= '0;
      core_r2_q    <= '0;
      core_n_q     <= '0;
      core_t_q     <= '0;
      resp_m_q     <= '0;
      resp_valid_q <= '0;
    end else if (ce) begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      idle_cnt_q   <= idle_cnt_d;
      core_c_q     <= core_c_d;
      core_d_q     <= core_d_d;
      core_r2_q    <= core_r2_d;
      core_n_q     <= core_n_d;
      core_t_q     <= core_t_d;
      resp_m_q     <= resp_m_d;
      resp_valid_q <= resp_valid_d;
    end
  end

  // Pulses are masked while stalled or in reset; a held resp_valid_q fires once ce returns
  assign go              = ce & ~rst;
  assign req_accept      = accept & {N_REQ{go}};
  assign resp_valid      = resp_valid_q & {N_REQ{go}};
  assign core_start      = start & go;
  assign pwr_req_enable  = pwr_en & go;
  assign pwr_req_disable = pwr_dis & go;
  assign resp_m          = resp_m_q;
  assign core_c          = core_c_q;
  assign core_d          = core_d_q;
  assign core_r2_mod_n   = core_r2_q;
  assign core_n          = core_n_q;
  assign core_t_sub_1    = core_t_q;

endmodule
